// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable Moore sequence detector.
// Pattern of 1..MAX_LEN bits with overlap/non-overlap modes, an input
// qualifier and a saturating match counter. With the reset configuration
// it behaves cycle-for-cycle like the fixed "1011" detector.
module seq_detector_prog #(
   parameter int                 MAX_LEN       = 8,
   parameter int                 CNT_W         = 8,
   parameter logic [MAX_LEN-1:0] RESET_PATTERN = 8'b0000_1011,
   parameter int                 RESET_LEN     = 4,
   parameter bit                 RESET_OVERLAP = 1'b1,
   localparam int                LEN_W         = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               sequence_in,
   output logic               detector_out,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   typedef enum logic {
      S_IDLE,
      S_HIT
   } state_t;

   state_t state, state_nxt;

   // Latched configuration
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   len;
   logic               ovl;

   // Only the previous MAX_LEN-1 samples are stored; together with the
   // incoming bit they form the full MAX_LEN-bit comparison window.
   logic [MAX_LEN-2:0] hist;
   logic [LEN_W-1:0]   fill;

   logic [LEN_W-1:0]   eff_len;
   logic [LEN_W-1:0]   fill_inc;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] mask;
   logic               hit;

   // Window, fill and match evaluation for the sample on the current edge
   always_comb begin
      eff_len  = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
      hist_nxt = {hist, sequence_in};
      fill_inc = (fill >= eff_len) ? eff_len : fill + LEN_W'(1);
      mask     = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < 32'(eff_len));
      end
      hit = (eff_len != '0) && (fill_inc == eff_len) &&
            ((hist_nxt & mask) == (pat & mask));
   end

   // Configuration, history, fill and saturating counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pat         <= RESET_PATTERN;
         len         <= LEN_W'(RESET_LEN);
         ovl         <= RESET_OVERLAP;
         hist        <= '0;
         fill        <= '0;
         match_count <= '0;
      end else if (cfg_load) begin
         pat         <= cfg_pattern;
         len         <= cfg_len;
         ovl         <= cfg_overlap;
         hist        <= '0;
         fill        <= '0;
         match_count <= '0;
      end else if (in_valid) begin
         hist <= hist_nxt[MAX_LEN-2:0];
         // Non-overlap restarts the fill so the next match needs L fresh bits
         fill <= (hit && !ovl) ? '0 : fill_inc;
         if (hit && !count_sat) begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

   // Match state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: re-evaluated only on valid samples, cleared by cfg_load
   always_comb begin
      state_nxt = state;
      if (cfg_load) begin
         state_nxt = S_IDLE;
      end else if (in_valid) begin
         state_nxt = hit ? S_HIT : S_IDLE;
      end
   end

   // Moore output decode
   always_comb begin
      detector_out = (state == S_HIT);
   end

   assign count_sat = &match_count;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and randomized checks of seq_detector_prog
// against a queue-based behavioural model, on two counter widths.
module tb_seq_detector_prog;

   logic       clock = 1'b0;
   logic       reset;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       in_valid;
   logic       sequence_in;
   logic       detector_out, det2;
   logic [7:0] match_count;
   logic [1:0] mc2;
   logic       count_sat, sat2;

   int n_err = 0;
   int n_chk = 0;
   bit chk_en = 1'b0;

   seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .in_valid(in_valid), .sequence_in(sequence_in),
      .detector_out(detector_out), .match_count(match_count), .count_sat(count_sat)
   );

   seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .in_valid(in_valid), .sequence_in(sequence_in),
      .detector_out(det2), .match_count(mc2), .count_sat(sat2)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: bits received since the last restart point
   bit       mq[$];
   bit [7:0] m_pat = 8'h0B;
   int       m_len = 4;
   bit       m_ovl = 1'b1;
   bit       m_det = 1'b0;
   int       m_cnt = 0;
   int       m_cnt2 = 0;
   bit       m_hit;

   // Model update on each edge or reset assertion
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
         m_det = 1'b0; m_cnt = 0; m_cnt2 = 0;
      end else if (cfg_load) begin
         m_pat = cfg_pattern;
         m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
         m_ovl = cfg_overlap;
         mq.delete();
         m_det = 1'b0; m_cnt = 0; m_cnt2 = 0;
      end else if (in_valid) begin
         mq.push_back(sequence_in);
         if (mq.size() > 8) void'(mq.pop_front());
         m_hit = (m_len > 0) && (mq.size() >= m_len);
         if (m_hit) begin
            for (int k = 0; k < m_len; k++) begin
               if (mq[mq.size() - 1 - k] != m_pat[k]) m_hit = 1'b0;
            end
         end
         m_det = m_hit;
         if (m_hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!m_ovl) mq.delete();
         end
      end
   end

   // Continuous comparison of both instances against the model
   always @(negedge clock) begin
      if (chk_en) begin
         chk("det", detector_out, m_det);
         chk("cnt", match_count, m_cnt);
         chk("sat", count_sat, m_cnt == 255);
         chk("det2", det2, m_det);
         chk("cnt2", mc2, m_cnt2);
         chk("sat2", sat2, m_cnt2 == 3);
      end
   end

   task automatic send(input bit b, output logic d);
      in_valid = 1'b1; sequence_in = b;
      @(negedge clock);
      d = detector_out;
      in_valid = 1'b0;
   endtask

   task automatic idle(output logic d);
      in_valid = 1'b0;
      @(negedge clock);
      d = detector_out;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o,
                       input bit v, input bit b);
      cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      in_valid = v; sequence_in = b;
      @(negedge clock);
      cfg_load = 1'b0; in_valid = 1'b0;
   endtask

   task automatic arst();
      #2 reset = 1'b0;
      #1;
      chk("arst_det", detector_out, 0);
      chk("arst_cnt", match_count, 0);
      @(negedge clock);
      #2 reset = 1'b1;
   endtask

   initial begin : stim
      logic d;
      int   b1[6]  = '{1, 0, 1, 1, 0, 0};
      int   e1[6]  = '{0, 0, 0, 1, 0, 0};
      int   b2[7]  = '{1, 0, 1, 1, 0, 1, 1};
      int   e2o[7] = '{0, 0, 0, 1, 0, 0, 1};
      int   e2n[7] = '{0, 0, 0, 1, 0, 0, 0};
      int   b3[8]  = '{1, 1, 0, 0, 1, 0, 1, 0};
      int   c5[5]  = '{1, 2, 3, 3, 3};
      int   s5[5]  = '{0, 0, 1, 1, 1};

      reset = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; in_valid = 1'b0; sequence_in = 1'b0;
      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      chk("rst_det", detector_out, 0);
      chk("rst_cnt", match_count, 0);
      chk("rst_sat", count_sat, 0);
      #2 reset = 1'b1;
      @(negedge clock);

      // Reset configuration, stream 101100
      foreach (b1[i]) begin
         send(b1[i][0], d);
         chk($sformatf("t1_det%0d", i), d, e1[i]);
      end
      chk("t1_cnt", match_count, 1);

      // Overlap versus non-overlap on 1011011
      load(8'h0B, 4'd4, 1'b1, 1'b0, 1'b0);
      foreach (b2[i]) begin
         send(b2[i][0], d);
         chk($sformatf("t2o_det%0d", i), d, e2o[i]);
      end
      chk("t2o_cnt", match_count, 2);
      load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
      foreach (b2[i]) begin
         send(b2[i][0], d);
         chk($sformatf("t2n_det%0d", i), d, e2n[i]);
      end
      chk("t2n_cnt", match_count, 1);

      // Eight-bit pattern with a valid gap mid-stream, then hold
      load(8'hCA, 4'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(b3[i][0], d);
      for (int i = 0; i < 3; i++) begin
         idle(d);
         chk("t3_gap", d, 0);
      end
      for (int i = 4; i < 8; i++) send(b3[i][0], d);
      chk("t3_hit", d, 1);
      for (int i = 0; i < 3; i++) begin
         idle(d);
         chk("t3_hold", d, 1);
      end
      chk("t3_cnt", match_count, 1);

      // Length zero disables detection; length 12 clamps to 8
      load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         send(1'($urandom), d);
         chk("t4_len0_det", d, 0);
      end
      chk("t4_len0_cnt", match_count, 0);
      load(8'hCA, 4'd12, 1'b0, 1'b0, 1'b0);
      foreach (b3[i]) send(b3[i][0], d);
      chk("t4_len12_hit", d, 1);
      chk("t4_len12_cnt", match_count, 1);

      // Single-bit pattern saturating the narrow counter
      load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send(1'b1, d);
         chk($sformatf("t5_det%0d", i), d, 1);
         chk($sformatf("t5_cnt2_%0d", i), mc2, c5[i]);
         chk($sformatf("t5_sat2_%0d", i), sat2, s5[i]);
         chk($sformatf("t5_cnt_%0d", i), match_count, i + 1);
      end

      // Async reset mid-sequence, then a fresh match
      arst();
      for (int i = 0; i < 4; i++) send(b1[i][0], d);
      chk("t6_pre_cnt", match_count, 1);
      send(1'b1, d); send(1'b0, d); send(1'b1, d);
      arst();
      send(1'b1, d);
      chk("t6_after_rst", d, 0);
      send(1'b0, d); send(1'b1, d); send(1'b1, d);
      chk("t6_fresh_hit", d, 1);
      chk("t6_fresh_cnt", match_count, 1);

      // cfg_load coincident with a valid sample discards that sample
      load(8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
      chk("t7_det", detector_out, 0);
      chk("t7_cnt", match_count, 0);
      send(1'b1, d);
      chk("t7_next", d, 1);

      // Randomized configurations and streams
      for (int c = 0; c < 40; c++) begin
         logic [3:0] l;
         l = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3))
                                         : 4'($urandom_range(0, 15));
         load(8'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom));
         for (int t = 0; t < 150; t++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            sequence_in = 1'($urandom);
            @(negedge clock);
            if ($urandom_range(0, 299) == 0) arst();
         end
         in_valid = 1'b0;
      end

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
